mux2_1_arbiter: RTL



---
 rtl/mux2_1_pkg.sv | 27 ++
 rtl/mux2_1_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux2_1_pkg.sv
// Purpose: shared encodings for the 2:1 mux arbiter and its integration wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux2_1_pkg;

  // One-hot state so each grant output is a flop bit, with no decode logic
  // between the state register and the mux select path.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_GRANT0 = 3'b010,
    ST_GRANT1 = 3'b100
  } state_t;

  localparam int ST_IDLE_BIT   = 0;
  localparam int ST_GRANT0_BIT = 1;
  localparam int ST_GRANT1_BIT = 2;

  // Mux select values: 0 routes i0, 1 routes i1.
  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  // Grant target for a requester index (0 or 1).
  function automatic state_t grant_state(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mux2_1_arbiter.sv
// Purpose: round-robin arbiter/sequencer that owns the select of a shared 2:1 mux.
// Latency: request sampled in IDLE at edge N -> grant after edge N; release -> handover in the same edge.
// Backpressure: a holder keeps the path up to MAX_HOLD beats while the other side waits, then yields.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/req1           requester wants / is using the path
//   last0/last1         final beat of a burst, qualified by reqx & gntx
//   gnt0/gnt1           requester owns the mux (registered, mutually exclusive)
//   sel                 mux select, 0 = i0, 1 = i1 (registered, holds in IDLE)
//   busy                gnt0 | gnt1 (registered)
//
// Parameters: MAX_HOLD in 1..15, and 2**CNT_W must exceed MAX_HOLD.
module mux2_1_arbiter
  import mux2_1_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic last0,
  input  logic req1,
  input  logic last1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_param
    $error("mux2_1_arbiter: MAX_HOLD must be 1..15 and below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             prio_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sel_q;
  logic             sel_nxt;
  // Set on the first edge after reset removal; no grant is issued before it,
  // so a grant never coincides with the edge that releases reset.
  logic             armed;

  // Holder-relative views of the request lines.
  logic own_req;
  logic own_last;
  logic other_req;
  logic holder;
  logic beat;
  logic release_now;

  always_comb begin
    holder    = 1'b0;
    own_req   = 1'b0;
    own_last  = 1'b0;
    other_req = 1'b0;
    if (state == ST_GRANT0) begin
      holder    = 1'b0;
      own_req   = req0;
      own_last  = last0;
      other_req = req1;
    end else if (state == ST_GRANT1) begin
      holder    = 1'b1;
      own_req   = req1;
      own_last  = last1;
      other_req = req0;
    end
  end

  // A beat is a granted cycle in which the holder still requests.
  assign beat = (state != ST_IDLE) && own_req;

  // Release on abandon, on the last beat, or when the hold budget is spent
  // and the other side is waiting. Last and preempt together act the same.
  assign release_now = (state != ST_IDLE) &&
                       (!own_req ||
                        (beat && own_last) ||
                        (beat && (cnt == CNT_LAST) && other_req));

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      ST_IDLE: begin
        if (armed) begin
          if (req0 && req1) begin
            state_nxt = grant_state(prio);
          end else if (req0) begin
            state_nxt = ST_GRANT0;
          end else if (req1) begin
            state_nxt = ST_GRANT1;
          end
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (release_now) begin
          // Favour the other side next time; hand over directly if it waits.
          prio_nxt  = ~holder;
          state_nxt = other_req ? grant_state(~holder) : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Beat counter clears on every state change and saturates at the budget,
  // so an unopposed holder can keep the path indefinitely.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (beat && (cnt != CNT_LAST)) begin
      cnt_nxt = cnt + CNT_ONE;
    end
  end

  // Select follows the owner and holds through IDLE to avoid needless toggles.
  always_comb begin
    sel_nxt = sel_q;
    if (state_nxt == ST_GRANT0) begin
      sel_nxt = SEL_I0;
    end else if (state_nxt == ST_GRANT1) begin
      sel_nxt = SEL_I1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
      sel_q <= SEL_I0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
      sel_q <= sel_nxt;
      armed <= 1'b1;
    end
  end

  // One-hot state bits are the grant flops themselves.
  assign gnt0 = state[ST_GRANT0_BIT];
  assign gnt1 = state[ST_GRANT1_BIT];
  assign busy = state[ST_GRANT0_BIT] | state[ST_GRANT1_BIT];
  assign sel  = sel_q;

endmodule
